z_core_icache_refill: RTL
=========================

// Module: z_core_icache_refill
// PURPOSE
//  Fetch-side controller for the direct-mapped instruction cache. Accepts word fetches from the core,
//  checks the cache and returns the word on a hit. On a miss it reads the word from memory over a
//  valid/ready read channel, writes it into the cache and returns it. Sits between the core fetch stage,
//  the instruction cache and the memory/bus read port.
// PARAMETERS
//  DATA_WIDTH     32  instruction/data word width
//  ADDR_WIDTH     32  byte address width
//  COUNTER_WIDTH  32  width of hit/miss statistics counters (wrap-around)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rstn         in   1              asynchronous active-low reset
//  req_valid    in   1              core fetch request valid
//  req_ready    out  1              controller can accept a request
//  req_addr     in   ADDR_WIDTH     fetch byte address; bits [1:0] ignored
//  rsp_valid    out  1              response valid
//  rsp_ready    in   1              core accepts response
//  rsp_data     out  DATA_WIDTH     fetched instruction
//  rsp_error    out  1              memory returned non-OKAY; rsp_data = 0
//  cache_addr   out  ADDR_WIDTH     address to cache (lookup and write)
//  cache_wen    out  1              cache write strobe, one cycle per refill
//  cache_wdata  out  DATA_WIDTH     refill data to cache
//  cache_rdata  in   DATA_WIDTH     cache combinational read data
//  cache_hit    in   1              cache combinational hit
//  mem_arvalid  out  1              memory read address valid
//  mem_arready  in   1              memory accepts address
//  mem_araddr   out  ADDR_WIDTH     word-aligned read address
//  mem_rvalid   in   1              memory read data valid
//  mem_rready   out  1              controller accepts read data
//  mem_rdata    in   DATA_WIDTH     memory read data
//  mem_rresp    in   2              2'b00 OKAY, anything else = error
//  hit_cnt      out  COUNTER_WIDTH  lookups that hit
//  miss_cnt     out  COUNTER_WIDTH  lookups that missed
// BEHAVIOUR
//  - Reset (rstn low, asynchronous): state IDLE, addr_q = 0, every output 0 except req_ready. req_ready = 1
//    once rstn is high. An in-flight memory transaction is abandoned; the memory side is reset with it.
//  - FSM IDLE -> LOOKUP -> (RESP | AR -> R -> RESP) -> IDLE.
//  - IDLE: req_ready = 1. On req_valid, latch addr_q = {req_addr[ADDR_WIDTH-1:2], 2'b00}; go to LOOKUP.
//  - LOOKUP (1 cycle): cache_addr = addr_q.
//    - If cache_hit: latch rsp_data = cache_rdata, rsp_error = 0, hit_cnt++, go to RESP.
//    - Otherwise: miss_cnt++, go to AR.
//  - AR: mem_arvalid = 1 and mem_araddr = addr_q, both held stable until mem_arready; then go to R.
//  - R: mem_rready = 1. On mem_rvalid:
//    - mem_rresp == 0: pulse cache_wen for exactly this cycle with cache_addr = addr_q and
//      cache_wdata = mem_rdata; latch rsp_data = mem_rdata, rsp_error = 0.
//    - mem_rresp != 0: no cache write; rsp_data = 0, rsp_error = 1.
//    - Either case: go to RESP.
//  - RESP: rsp_valid = 1; rsp_data and rsp_error are registered and held stable until rsp_ready; then go
//    to IDLE. req_ready = 0 in every state except IDLE (one outstanding fetch).
//  - Latency from request acceptance edge: hit = rsp_valid 2 cycles later. Miss = 2 cycles + AR wait +
//    R wait + 1.
//  - mem_rvalid outside R is ignored; mem_rready = 0 and mem_arvalid = 0 outside R/AR. cache_wen is never
//    asserted outside R.
//  - Counters are free-running and wrap from all-ones to 0. Each increments at most once per request.
//  - cache_addr = addr_q in all states.
// TESTING
//  1. Reset mid-R (rstn low for 1 cycle) -> all outputs 0 immediately; req_ready=1 after release;
//     no cache_wen.
//  2. Cold fetch 0x0000_0103, cache_hit=0, arready after 2 cycles, rdata 0x00500093 -> mem_araddr
//     0x0000_0100; one cache_wen with data 0x00500093; rsp_data 0x00500093; miss_cnt=1.
//  3. Fetch 0x100 with cache_hit=1, rdata 0x00500093 -> rsp_valid 2 cycles after accept; no mem_arvalid;
//     hit_cnt=1.
//  4. Miss with mem_rresp=2'b10 -> rsp_error=1, rsp_data=0, cache_wen never high.
//  5. rsp_ready low for 3 cycles in RESP -> rsp_valid/rsp_data stable; req_ready=0; a new req_valid
//     is not accepted.
//  6. COUNTER_WIDTH=4, 16 consecutive hits -> hit_cnt wraps to 0; miss_cnt unchanged.

Source files
------------

// File: rtl/z_core_icache_refill.sv
// Fetch-side refill controller for a direct-mapped instruction cache.
// Serves one core fetch at a time: cache lookup, and on a miss a single-word memory read plus a cache refill.
module z_core_icache_refill #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_error,
  output logic [ADDR_WIDTH-1:0]    cache_addr,
  output logic                     cache_wen,
  output logic [DATA_WIDTH-1:0]    cache_wdata,
  input  logic [DATA_WIDTH-1:0]    cache_rdata,
  input  logic                     cache_hit,
  output logic                     mem_arvalid,
  input  logic                     mem_arready,
  output logic [ADDR_WIDTH-1:0]    mem_araddr,
  input  logic                     mem_rvalid,
  output logic                     mem_rready,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic [1:0]               mem_rresp,
  output logic [COUNTER_WIDTH-1:0] hit_cnt,
  output logic [COUNTER_WIDTH-1:0] miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_error;
  logic [COUNTER_WIDTH-1:0] r_hit_cnt;
  logic [COUNTER_WIDTH-1:0] r_miss_cnt;

  logic w_accept;
  logic w_lookup_hit;
  logic w_lookup_miss;
  logic w_r_take;
  logic w_r_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // req_ready is gated by rstn so that every output reads 0 while reset is held.
  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_lookup_hit  = 1'b0;
    w_lookup_miss = 1'b0;
    w_r_take      = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    mem_arvalid   = 1'b0;
    mem_rready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = rstn;
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          w_lookup_hit = 1'b1;
          w_next       = S_RESP;
        end else begin
          w_lookup_miss = 1'b1;
          w_next        = S_AR;
        end
      end
      S_AR: begin
        mem_arvalid = 1'b1;
        if (mem_arready) begin
          w_next = S_R;
        end
      end
      S_R: begin
        mem_rready = 1'b1;
        if (mem_rvalid) begin
          w_r_take = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign w_r_ok      = w_r_take && (mem_rresp == 2'b00);
  assign cache_wen   = w_r_ok;
  assign cache_wdata = w_r_ok ? mem_rdata : '0;

  // Masking keeps the whole request address in use while forcing word alignment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr & ~ADDR_WIDTH'(3);
      end
      if (w_lookup_hit) begin
        r_rsp_data  <= cache_rdata;
        r_rsp_error <= 1'b0;
        r_hit_cnt   <= r_hit_cnt + COUNTER_WIDTH'(1);
      end
      if (w_lookup_miss) begin
        r_miss_cnt <= r_miss_cnt + COUNTER_WIDTH'(1);
      end
      if (w_r_take) begin
        r_rsp_data  <= w_r_ok ? mem_rdata : '0;
        r_rsp_error <= !w_r_ok;
      end
    end
  end

  assign rsp_data   = r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign cache_addr = r_addr;
  assign mem_araddr = r_addr;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;

endmodule
